// File: rtl/muldiv_if.sv
// Execute-stage port bundle for the HI/LO multiply/divide unit.
// master = pipeline control side, slave = muldiv_unit.
interface muldiv_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wr_data;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, flush, hi_we, lo_we, wr_data,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, flush, hi_we, lo_we, wr_data,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Magnitudes are processed unsigned; signs are reapplied in the FINISH cycle.
//
// state  | meaning
// IDLE   | waiting for start; MTHI/MTLO writes honoured
// RUN    | one shift-add / shift-subtract step per clock, ITERS steps
// FINISH | sign correction, HI/LO update, done pulse
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int ITERS = 32
) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);

  localparam int CW = $clog2(ITERS);
  localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic               is_div;
  logic [WIDTH-1:0]   a_raw;
  logic               b_zero;
  logic               neg_q;
  logic               neg_r;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] acc;

  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;

  always_comb begin
    abs_a = (bus.op[0] && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    abs_b = (bus.op[0] && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    // multiply: acc = {partial product, remaining multiplier bits}
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    mul_next = {mul_sum, acc[WIDTH-1:1]};

    // divide: acc = {partial remainder, dividend bits shifting into quotient}
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = div_shift[WIDTH-1:0] - opnd;
    if (div_shift >= {1'b0, opnd})
      div_next = {div_diff, acc[WIDTH-2:0], 1'b1};
    else
      div_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};

    prod = neg_q ? -acc : acc;
    quo  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      is_div   <= 1'b0;
      a_raw    <= '0;
      b_zero   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      opnd     <= '0;
      acc      <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.hi   <= '0;
      bus.lo   <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.hi_we) bus.hi <= bus.wr_data;
          if (bus.lo_we) bus.lo <= bus.wr_data;
          if (bus.start && !bus.flush) begin
            is_div   <= bus.op[1];
            a_raw    <= bus.a;
            b_zero   <= (bus.b == '0);
            neg_q    <= bus.op[0] && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            neg_r    <= bus.op[0] && bus.a[WIDTH-1];
            acc      <= {{WIDTH{1'b0}}, bus.op[1] ? abs_a : abs_b};
            opnd     <= bus.op[1] ? abs_b : abs_a;
            cnt      <= '0;
            state    <= RUN;
            bus.busy <= 1'b1;
          end
        end
        RUN: begin
          if (bus.flush) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end else begin
            acc <= is_div ? div_next : mul_next;
            cnt <= cnt + 1'b1;
            if (cnt == LAST) state <= FINISH;
          end
        end
        FINISH: begin
          if (!bus.flush) begin
            if (!is_div) begin
              bus.hi <= prod[2*WIDTH-1:WIDTH];
              bus.lo <= prod[WIDTH-1:0];
            end else if (b_zero) begin
              // divide by zero: no trap, HI gets the untouched dividend
              bus.hi <= a_raw;
              bus.lo <= '1;
            end else begin
              bus.hi <= rem;
              bus.lo <= quo;
            end
            bus.done <= 1'b1;
          end
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: expected HI/LO pairs are queued at issue
// and a negedge monitor pops one per done pulse.
module tb_muldiv_unit;

  logic clk;
  logic rst;
  int   pass_cnt = 0;
  int   chk_cnt  = 0;
  logic [63:0] exp_q[$];

  muldiv_if #(.WIDTH(32)) bus ();

  muldiv_unit #(.WIDTH(32), .ITERS(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[6] = '{
    '{2'b01, 32'hFFFFFFFD, 32'h00000007, 64'hFFFFFFFF_FFFFFFEB},
    '{2'b11, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD},
    '{2'b10, 32'd100,      32'h00000000, 64'h00000064_FFFFFFFF},
    '{2'b11, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000},
    '{2'b11, 32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD},
    '{2'b11, 32'hFFFFFFF9, 32'h00000000, 64'hFFFFFFF9_FFFFFFFF}
  };

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // caller must be sitting just after a negedge
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit push, input logic [63:0] exp);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    if (push) exp_q.push_back(exp);
  endtask

  task automatic wait_done(output int lat, output int busy_cycles);
    lat = 0;
    busy_cycles = 0;
    do begin
      @(negedge clk);
      bus.start = 1'b0;
      lat++;
      if (bus.busy && !bus.done) busy_cycles++;
    end while (!bus.done && lat < 60);
    if (!bus.done) begin
      chk_cnt++;
      $display("FAIL done_timeout: no done after %0d cycles", lat);
    end
  endtask

  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk_cnt++;
        $display("FAIL unexpected_done: hi=%h lo=%h with nothing expected", bus.hi, bus.lo);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("result_hi", {32'h0, bus.hi}, {32'h0, e[63:32]});
        check("result_lo", {32'h0, bus.lo}, {32'h0, e[31:0]});
      end
    end
  end

  initial begin
    int lat, bc, dcount;
    bus.start = 0; bus.op = 0; bus.a = 0; bus.b = 0; bus.flush = 0;
    bus.hi_we = 0; bus.lo_we = 0; bus.wr_data = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_busy", {63'h0, bus.busy}, 64'h0);
    check("reset_done", {63'h0, bus.done}, 64'h0);
    check("reset_hi",   {32'h0, bus.hi}, 64'h0);
    check("reset_lo",   {32'h0, bus.lo}, 64'h0);
    rst = 1'b0;
    @(negedge clk);

    // MULTU max*max with latency / busy-length / single-pulse checks
    issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 64'hFFFFFFFE_00000001);
    wait_done(lat, bc);
    check("multu_latency", 64'(lat), 64'd34);
    check("multu_busy_cycles", 64'(bc), 64'd33);
    @(negedge clk);
    check("done_single_pulse", {63'h0, bus.done}, 64'h0);

    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, 1, vecs[i].exp);
      wait_done(lat, bc);
      @(negedge clk);
    end

    // DIVU 17/5 with an ignored Start mid-flight, then back-to-back issue
    issue(2'b10, 32'd17, 32'd5, 1, 64'h00000002_00000003);
    repeat (10) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    issue(2'b00, 32'd2, 32'd3, 0, 64'h0);
    wait_done(lat, bc);
    issue(2'b00, 32'd2, 32'd3, 1, 64'h00000000_00000006);
    wait_done(lat, bc);
    check("back_to_back_latency", 64'(lat), 64'd34);
    @(negedge clk);

    // MTHI in idle, MTLO while busy ignored, flush drops the operation
    bus.hi_we = 1'b1;
    bus.wr_data = 32'h1234;
    @(negedge clk);
    bus.hi_we = 1'b0;
    check("mthi_idle", {32'h0, bus.hi}, 64'h1234);
    issue(2'b01, 32'd4, 32'd5, 0, 64'h0);
    repeat (15) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    bus.lo_we = 1'b1;
    bus.wr_data = 32'hDEAD;
    @(negedge clk);
    bus.lo_we = 1'b0;
    check("mtlo_busy_ignored", {32'h0, bus.lo}, 64'h6);
    repeat (4) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_busy_drop", {63'h0, bus.busy}, 64'h0);
    dcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) dcount++;
    end
    check("flush_no_done", 64'(dcount), 64'h0);
    check("flush_hi_kept", {32'h0, bus.hi}, 64'h1234);
    check("flush_lo_kept", {32'h0, bus.lo}, 64'h6);

    // asynchronous reset mid-run, away from any clock edge
    issue(2'b00, 32'd7, 32'd9, 0, 64'h0);
    repeat (10) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    check("async_rst_busy", {63'h0, bus.busy}, 64'h0);
    check("async_rst_done", {63'h0, bus.done}, 64'h0);
    check("async_rst_hi",   {32'h0, bus.hi}, 64'h0);
    check("async_rst_lo",   {32'h0, bus.lo}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(2'b10, 32'd9, 32'd3, 1, 64'h00000000_00000003);
    wait_done(lat, bc);
    repeat (3) @(negedge clk);

    check("scoreboard_drained", 64'(exp_q.size()), 64'h0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
